// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu operation sequencer: defaults, state encoding,
// instruction field positions and the registered flag bundle.
package alu_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREGS_DEF = 4;

    // Sequencer states; the fourth code is unused and recovers to ST_IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Instruction layout, MSB first: {L, Op[1:0], rd, ra, rb}.
    // Each register-address field is ra_w bits wide.
    function automatic int instr_w(input int ra_w);
        return 3 * ra_w + 3;
    endfunction

    function automatic int rb_lsb(input int ra_w);
        return 0 * ra_w;
    endfunction

    function automatic int rb_msb(input int ra_w);
        return ra_w - 1;
    endfunction

    function automatic int ra_lsb(input int ra_w);
        return ra_w;
    endfunction

    function automatic int ra_msb(input int ra_w);
        return 2 * ra_w - 1;
    endfunction

    function automatic int rd_lsb(input int ra_w);
        return 2 * ra_w;
    endfunction

    function automatic int rd_msb(input int ra_w);
        return 3 * ra_w - 1;
    endfunction

    function automatic int op_lsb(input int ra_w);
        return 3 * ra_w;
    endfunction

    function automatic int op_msb(input int ra_w);
        return 3 * ra_w + 1;
    endfunction

    function automatic int l_bit(input int ra_w);
        return 3 * ra_w + 2;
    endfunction

    typedef struct packed {
        logic z;
        logic c;
        logic s;
    } alu_flags_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two operand read ports, one debug read port and a
// single write port where the sequencer writeback takes priority over direct loads.
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_en,
    input  logic [RA_W-1:0]  wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [RA_W-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [RA_W-1:0]  rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [RA_W-1:0]  rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic [RA_W-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
            if (wb_en && (wb_addr == RA_W'(i))) begin
                mem_d[i] = wb_data;
            end else if (ld_en && (ld_addr == RA_W'(i))) begin
                mem_d[i] = ld_data;
            end
        end
    end

    // NOTE: this storage is tiny and must read back as zero after reset, so it is
    // built from resettable flops; a large RAM would normally not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_a_data = mem_q[rd_a_addr];
    assign rd_b_data = mem_q[rd_b_addr];
    assign dbg_data  = mem_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Controller for an external combinational alu: accepts an instruction, presents
// register operands, captures the result and flags, writes back and hands the result on.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int RA_W  = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [instr_w(RA_W)-1:0]  in_instr,
    input  logic                      ld_valid,
    input  logic [RA_W-1:0]           ld_addr,
    input  logic [WIDTH-1:0]          ld_data,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [1:0]                alu_op,
    output logic                      alu_l,
    input  logic [WIDTH-1:0]          alu_r,
    input  logic                      alu_z,
    input  logic                      alu_c,
    input  logic                      alu_s,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [WIDTH-1:0]          res_data,
    output logic                      flag_z,
    output logic                      flag_c,
    output logic                      flag_s,
    input  logic [RA_W-1:0]           dbg_addr,
    output logic [WIDTH-1:0]          dbg_data
);

    logic [RA_W-1:0] instr_rd;
    logic [RA_W-1:0] instr_ra;
    logic [RA_W-1:0] instr_rb;
    logic [1:0]      instr_op;
    logic            instr_l;

    assign instr_rb = in_instr[rb_msb(RA_W):rb_lsb(RA_W)];
    assign instr_ra = in_instr[ra_msb(RA_W):ra_lsb(RA_W)];
    assign instr_rd = in_instr[rd_msb(RA_W):rd_lsb(RA_W)];
    assign instr_op = in_instr[op_msb(RA_W):op_lsb(RA_W)];
    assign instr_l  = in_instr[l_bit(RA_W)];

    logic [1:0]       state_q,     state_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [1:0]       alu_op_q,    alu_op_d;
    logic             alu_l_q,     alu_l_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_valid_q, res_valid_d;
    alu_flags_t       flags_q,     flags_d;

    logic [WIDTH-1:0] rf_a_data;
    logic [WIDTH-1:0] rf_b_data;
    logic             wb_en;

    // Writeback happens on the edge that ends EXEC, the same edge that captures R.
    assign wb_en = (state_q == ST_EXEC);

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RA_W  (RA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .wb_addr   (rd_q),
        .wb_data   (alu_r),
        .ld_en     (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_a_addr (instr_ra),
        .rd_a_data (rf_a_data),
        .rd_b_addr (instr_rb),
        .rd_b_data (rf_b_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // NOTE: combinational next-state logic uses blocking assignments; the flops
    // below use non-blocking ones so every register samples pre-edge values.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_l_d     = alu_l_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        flags_d     = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rd_d     = instr_rd;
                    alu_a_d  = rf_a_data;
                    alu_b_d  = rf_b_data;
                    alu_op_d = instr_op;
                    alu_l_d  = instr_l;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d  = alu_r;
                flags_d     = '{z: alu_z, c: alu_c, s: alu_s};
                res_valid_d = 1'b1;
                state_d     = ST_WB;
            end
            ST_WB: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_l_q     <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_l_q     <= alu_l_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_l     = alu_l_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_s    = flags_q.s;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder stub standing in for the alu.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_instr;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_z;
    logic       alu_c;
    logic       alu_s;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       flag_z;
    logic       flag_c;
    logic       flag_s;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Stub alu: R = A + B mod 16, c = carry out, z = (R == 0), s = R[3].
    logic [4:0] stub_sum;
    assign stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_r    = stub_sum[3:0];
    assign alu_c    = stub_sum[4];
    assign alu_z    = (stub_sum[3:0] == 4'd0);
    assign alu_s    = stub_sum[3];

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_l     (alu_l),
        .alu_r     (alu_r),
        .alu_z     (alu_z),
        .alu_c     (alu_c),
        .alu_s     (alu_s),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_s    (flag_s),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic l, input logic [1:0] op,
                                      input logic [1:0] rd, input logic [1:0] ra,
                                      input logic [1:0] rb);
        return {l, op, rd, ra, rb};
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic ld_write(input logic [1:0] addr, input logic [3:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic check_rf(input string name, input logic [1:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    typedef struct {
        logic [3:0] a_val;
        logic [3:0] b_val;
        logic       l;
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] exp_r;
        logic       exp_z;
        logic       exp_c;
        logic       exp_s;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input int idx, input vec_t v);
        ld_write(v.ra, v.a_val);
        if (v.rb != v.ra) ld_write(v.rb, v.b_val);
        check($sformatf("v%0d_in_ready_idle", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_instr = mk(v.l, v.op, v.rd, v.ra, v.rb);
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("v%0d_alu_a", idx), 32'(alu_a), 32'(v.a_val));
        check($sformatf("v%0d_alu_b", idx), 32'(alu_b), 32'(v.b_val));
        check($sformatf("v%0d_alu_op", idx), 32'(alu_op), 32'(v.op));
        check($sformatf("v%0d_alu_l", idx), 32'(alu_l), 32'(v.l));
        check($sformatf("v%0d_valid_early", idx), 32'(res_valid), 32'd0);
        check($sformatf("v%0d_in_ready_exec", idx), 32'(in_ready), 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_res_valid", idx), 32'(res_valid), 32'd1);
        check($sformatf("v%0d_res_data", idx), 32'(res_data), 32'(v.exp_r));
        check($sformatf("v%0d_flags", idx), 32'({flag_z, flag_c, flag_s}),
              32'({v.exp_z, v.exp_c, v.exp_s}));
        check_rf($sformatf("v%0d_rf_rd", idx), v.rd, v.exp_r);
        @(negedge clk);
        check($sformatf("v%0d_valid_done", idx), 32'(res_valid), 32'd0);
        check($sformatf("v%0d_in_ready_back", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int last_acc;
        int n_acc;
        int n_res;
        logic [3:0] model;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        res_ready = 1'b1;
        dbg_addr  = '0;

        //                a     b     L     op     rd     ra     rb     R     z     c     s
        vecs[0] = '{4'h7, 4'hB, 1'b0, 2'b10, 2'd2, 2'd0, 2'd1, 4'h2, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'h8, 4'h8, 1'b1, 2'b11, 2'd0, 2'd0, 2'd1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{4'h5, 4'h5, 1'b1, 2'b00, 2'd1, 2'd3, 2'd3, 4'hA, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{4'h3, 4'h4, 1'b0, 2'b01, 2'd3, 2'd2, 2'd3, 4'h7, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{4'hF, 4'h1, 1'b1, 2'b10, 2'd1, 2'd1, 2'd2, 4'h0, 1'b1, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b, alu_op, alu_l}), 32'd0);
        check("rst_res_flags", 32'({res_data, flag_z, flag_c, flag_s}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) check_rf($sformatf("rst_rf%0d", i), 2'(i), 4'h0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Result held under backpressure; a pending instruction waits for the handshake.
        ld_write(2'd0, 4'h6);
        ld_write(2'd1, 4'h2);
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(1'b0, 2'b01, 2'd3, 2'd0, 2'd1);
        @(negedge clk);
        in_instr  = mk(1'b1, 2'b10, 2'd1, 2'd3, 2'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_data", k), 32'(res_data), 32'h8);
            check($sformatf("bp%0d_flags", k), 32'({flag_z, flag_c, flag_s}), 32'b001);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_alu_a", k), 32'(alu_a), 32'h6);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(res_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_not_yet_accepted", 32'(alu_a), 32'h6);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_alu_a", 32'(alu_a), 32'h8);
        check("bp_next_alu_b", 32'(alu_b), 32'h6);
        check("bp_next_op_l", 32'({alu_l, alu_op}), 32'b110);
        @(negedge clk);
        check("bp_next_res", 32'(res_data), 32'hE);
        check("bp_next_flags", 32'({flag_z, flag_c, flag_s}), 32'b001);
        @(negedge clk);

        // Direct load colliding with writeback: same address loses, other address lands.
        ld_write(2'd0, 4'h3);
        ld_write(2'd1, 4'h4);
        in_valid = 1'b1;
        in_instr = mk(1'b0, 2'b00, 2'd2, 2'd0, 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        ld_write(2'd2, 4'hF);
        check_rf("coll_same_addr", 2'd2, 4'h7);
        @(negedge clk);
        ld_write(2'd0, 4'h1);
        ld_write(2'd1, 4'h1);
        in_valid = 1'b1;
        in_instr = mk(1'b0, 2'b00, 2'd2, 2'd0, 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        ld_write(2'd3, 4'h9);
        check_rf("coll_diff_wb", 2'd2, 4'h2);
        check_rf("coll_diff_ld", 2'd3, 4'h9);
        @(negedge clk);

        // Reset while the instruction is in EXEC.
        ld_write(2'd0, 4'h5);
        ld_write(2'd1, 4'h6);
        in_valid = 1'b1;
        in_instr = mk(1'b1, 2'b11, 2'd2, 2'd0, 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_alu_a_loaded", 32'(alu_a), 32'h5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_op, alu_l}), 32'd0);
        check("mid_rst_res", 32'({res_valid, res_data, flag_z, flag_c, flag_s}), 32'd0);
        check_rf("mid_rst_rf0", 2'd0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_rf("mid_rst_rf2", 2'd2, 4'h0);

        // Back-to-back with res_ready high: one accept every third cycle.
        ld_write(2'd0, 4'h1);
        ld_write(2'd1, 4'h1);
        in_valid = 1'b1;
        in_instr = mk(1'b0, 2'b00, 2'd0, 2'd0, 2'd1);
        last_acc = -1;
        n_acc    = 0;
        n_res    = 0;
        model    = 4'h1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready) begin
                if (last_acc >= 0) check($sformatf("b2b_gap%0d", i), 32'(i - last_acc), 32'd3);
                last_acc = i;
                n_acc++;
            end
            if (res_valid) begin
                model = model + 4'h1;
                check($sformatf("b2b_res%0d", n_res), 32'(res_data), 32'(model));
                n_res++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_results", 32'(n_res), 32'd3);
        check_rf("b2b_rf0", 2'd0, 4'h4);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
